// File: rtl/clint_ctrl_if.sv
// Request/response bus between the memory stage (master) and the core-local interruptor (slave).
interface clint_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [63:0] req_wdata;
  logic [7:0]  req_strb;
  logic        resp_valid;
  logic        resp_ready;
  logic [63:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_strb, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_strb, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/clint_ctrl.sv
// Core-local interruptor: memory-mapped msip/mtimecmp/mtime plus timer/software/external interrupt levels.
// Define CLINT_EXINT_SYNC_EN to pass ext_irq through a 2-flop synchronizer instead of a single register.
module clint_ctrl #(
  parameter logic [31:0] BASE_ADDR = 32'h0200_0000,
  parameter int unsigned TICK_DIV  = 1
) (
  input  logic         clk,
  input  logic         reset,
  clint_ctrl_if.slave  bus,
  input  logic         ext_irq,
  output logic         trint,
  output logic         swint,
  output logic         exint,
  output logic [63:0]  mtime_o
);

  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
  localparam logic [31:0] MSIP_ADDR     = BASE_ADDR + 32'h0000_0000;
  localparam logic [31:0] MTIMECMP_ADDR = BASE_ADDR + 32'h0000_4000;
  localparam logic [31:0] MTIME_ADDR    = BASE_ADDR + 32'h0000_BFF8;

  typedef enum logic {IDLE, RESP} state_t;

  state_t      state_q;
  logic        req_ready_q;
  logic        resp_valid_q;
  logic [63:0] rdata_q;
  logic        err_q;

  logic        msip_q, msip_d;
  logic [63:0] mtimecmp_q, mtimecmp_d;
  logic [63:0] mtime_q, mtime_d;
  logic [PW-1:0] presc_q;
  logic        trint_q;
  logic        exint_q;

  logic        accept;
  logic        tick;
  logic        wr_en;
  logic [31:0] dw_addr;
  logic        sel_msip, sel_cmp, sel_mtime, hit;
  logic [63:0] wmask;
  logic [63:0] rd_sel;

  assign accept    = bus.req_valid && req_ready_q;
  assign tick      = (presc_q == PRESC_MAX);
  assign dw_addr   = bus.req_addr & ~32'h7;
  assign sel_msip  = (dw_addr == MSIP_ADDR);
  assign sel_cmp   = (dw_addr == MTIMECMP_ADDR);
  assign sel_mtime = (dw_addr == MTIME_ADDR);
  assign hit       = sel_msip || sel_cmp || sel_mtime;
  // An all-zero strobe must not disturb anything, including a coincident mtime tick.
  assign wr_en     = accept && bus.req_write && hit && (bus.req_strb != 8'h00);

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_wmask
      assign wmask[gi*8 +: 8] = {8{bus.req_strb[gi]}};
    end
  endgenerate

  always_comb begin
    rd_sel = 64'h0;
    if (sel_msip)       rd_sel = {63'h0, msip_q};
    else if (sel_cmp)   rd_sel = mtimecmp_q;
    else if (sel_mtime) rd_sel = mtime_q;
  end

  always_comb begin
    msip_d     = msip_q;
    mtimecmp_d = mtimecmp_q;
    mtime_d    = tick ? mtime_q + 64'd1 : mtime_q;
    if (wr_en && sel_msip && bus.req_strb[0])
      msip_d = bus.req_wdata[0];
    if (wr_en && sel_cmp)
      mtimecmp_d = (mtimecmp_q & ~wmask) | (bus.req_wdata & wmask);
    if (wr_en && sel_mtime)
      mtime_d = (mtime_q & ~wmask) | (bus.req_wdata & wmask);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      rdata_q      <= 64'h0;
      err_q        <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            state_q      <= RESP;
            req_ready_q  <= 1'b0;
            resp_valid_q <= 1'b1;
            rdata_q      <= (bus.req_write || !hit) ? 64'h0 : rd_sel;
            err_q        <= !hit;
          end
        end
        RESP: begin
          if (bus.resp_ready) begin
            state_q      <= IDLE;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            rdata_q      <= 64'h0;
            err_q        <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      msip_q     <= 1'b0;
      mtimecmp_q <= 64'hFFFF_FFFF_FFFF_FFFF;
      mtime_q    <= 64'h0;
      presc_q    <= '0;
      trint_q    <= 1'b0;
    end else begin
      msip_q     <= msip_d;
      mtimecmp_q <= mtimecmp_d;
      mtime_q    <= mtime_d;
      presc_q    <= tick ? '0 : presc_q + PW'(1);
      trint_q    <= (mtime_q >= mtimecmp_q);
    end
  end

`ifdef CLINT_EXINT_SYNC_EN
  logic ext_meta_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      ext_meta_q <= 1'b0;
      exint_q    <= 1'b0;
    end else begin
      ext_meta_q <= ext_irq;
      exint_q    <= ext_meta_q;
    end
  end
`else
  always_ff @(posedge clk) begin
    if (reset) exint_q <= 1'b0;
    else       exint_q <= ext_irq;
  end
`endif

  assign bus.req_ready  = req_ready_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_rdata = rdata_q;
  assign bus.resp_err   = err_q;
  assign trint          = trint_q;
  assign swint          = msip_q;
  assign exint          = exint_q;
  assign mtime_o        = mtime_q;

endmodule

// File: tb/tb_clint_ctrl.sv
// Directed bench for clint_ctrl: bus accesses, timer/software/external interrupt levels, reset behaviour.
module tb_clint_ctrl;
  localparam logic [31:0] BASE = 32'h0200_0000;
  localparam logic [31:0] A_MSIP  = BASE + 32'h0000;
  localparam logic [31:0] A_CMP   = BASE + 32'h4000;
  localparam logic [31:0] A_MTIME = BASE + 32'hBFF8;
`ifdef CLINT_EXINT_SYNC_EN
  localparam int LAG = 2;
`else
  localparam int LAG = 1;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        ext_irq;
  logic        trint, swint, exint;
  logic [63:0] mtime_o;
  int          n_cmp = 0;
  int          n_bad = 0;

  clint_ctrl_if bus ();

  clint_ctrl #(.BASE_ADDR(BASE), .TICK_DIV(1)) dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus),
    .ext_irq (ext_irq),
    .trint   (trint),
    .swint   (swint),
    .exint   (exint),
    .mtime_o (mtime_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issues one request at the current negedge with resp_ready high; returns the response and
  // the trint level seen in the response cycle.
  task automatic xfer(input logic wr, input logic [31:0] addr, input logic [63:0] wd,
                      input logic [7:0] strb, output logic [63:0] rd, output logic err,
                      output logic tr_mid);
    chk("xfer_req_ready", bus.req_ready, 1'b1);
    bus.req_valid  = 1'b1;
    bus.req_write  = wr;
    bus.req_addr   = addr;
    bus.req_wdata  = wd;
    bus.req_strb   = strb;
    bus.resp_ready = 1'b1;
    @(negedge clk);
    bus.req_valid  = 1'b0;
    bus.req_write  = 1'b0;
    bus.req_strb   = 8'h00;
    chk("xfer_resp_latency", bus.resp_valid, 1'b1);
    rd     = bus.resp_rdata;
    err    = bus.resp_err;
    tr_mid = trint;
    @(negedge clk);
    chk("xfer_resp_done", bus.resp_valid, 1'b0);
    $display("xfer %s addr=%08h wdata=%016h strb=%02h -> rdata=%016h err=%0b",
             wr ? "WR" : "RD", addr, wd, strb, rd, err);
  endtask

  initial begin
    logic [63:0] rd;
    logic        err;
    logic        tr_mid;
    logic        exp_ex;
    int          waited;

    reset          = 1'b1;
    ext_irq        = 1'b0;
    bus.req_valid  = 1'b0;
    bus.req_write  = 1'b0;
    bus.req_addr   = 32'h0;
    bus.req_wdata  = 64'h0;
    bus.req_strb   = 8'h00;
    bus.resp_ready = 1'b1;
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_mtime", mtime_o, 64'h0);
    chk("rst_req_ready", bus.req_ready, 1'b1);
    chk("rst_resp_valid", bus.resp_valid, 1'b0);
    chk("rst_rdata", bus.resp_rdata, 64'h0);
    chk("rst_err", bus.resp_err, 1'b0);
    chk("rst_trint", trint, 1'b0);
    chk("rst_swint", swint, 1'b0);
    chk("rst_exint", exint, 1'b0);
    reset = 1'b0;

    // Free-running mtime
    repeat (10) @(negedge clk);
    chk("run10_mtime", mtime_o, 64'd10);
    chk("run10_trint", trint, 1'b0);
    chk("run10_swint", swint, 1'b0);
    chk("run10_req_ready", bus.req_ready, 1'b1);
    $display("step reset+10 cycles: mtime=%0d", mtime_o);

    // Timer compare
    xfer(1'b1, A_CMP, 64'd20, 8'hFF, rd, err, tr_mid);
    chk("cmp_wr_err", err, 1'b0);
    chk("cmp_wr_rdata", rd, 64'h0);
    waited = 0;
    while (mtime_o != 64'd20 && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 50) begin
      n_bad++;
      $error("FAIL cmp_wait_expired: mtime_o never reached 20 within %0d cycles", waited);
    end
    n_cmp++;
    chk("cmp_reach20", mtime_o, 64'd20);
    chk("cmp_trint_before", trint, 1'b0);
    @(negedge clk);
    chk("cmp_trint_rise", trint, 1'b1);
    $display("step timer compare: trint=%0b at mtime=%0d", trint, mtime_o);

    // Software interrupt
    xfer(1'b1, A_MSIP, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, rd, err, tr_mid);
    chk("msip_set_swint", swint, 1'b1);
    xfer(1'b0, A_MSIP, 64'h0, 8'h00, rd, err, tr_mid);
    chk("msip_rd_val", rd, 64'h1);
    chk("msip_rd_err", err, 1'b0);
    xfer(1'b1, A_MSIP, 64'h0, 8'h00, rd, err, tr_mid);
    chk("msip_strb0_err", err, 1'b0);
    chk("msip_strb0_keep", swint, 1'b1);
    xfer(1'b1, A_MSIP, 64'h0, 8'h01, rd, err, tr_mid);
    chk("msip_clr_swint", swint, 1'b0);
    xfer(1'b0, A_MSIP, 64'h0, 8'h00, rd, err, tr_mid);
    chk("msip_rd_zero", rd, 64'h0);

    // mtimecmp raised: trint drops two cycles after accept
    xfer(1'b1, A_CMP, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, rd, err, tr_mid);
    chk("cmpmax_trint_mid", tr_mid, 1'b1);
    chk("cmpmax_trint_drop", trint, 1'b0);
    xfer(1'b0, A_CMP, 64'h0, 8'h00, rd, err, tr_mid);
    chk("cmpmax_rd", rd, 64'hFFFF_FFFF_FFFF_FFFF);

    // mtime wrap
    xfer(1'b1, A_MTIME, 64'hFFFF_FFFF_FFFF_FFFE, 8'hFF, rd, err, tr_mid);
    chk("wrap_trint_mid", tr_mid, 1'b0);
    chk("wrap_mtime_max", mtime_o, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("wrap_trint_pre", trint, 1'b0);
    @(negedge clk);
    chk("wrap_mtime_zero", mtime_o, 64'h0);
    chk("wrap_trint_hit", trint, 1'b1);
    @(negedge clk);
    chk("wrap_mtime_one", mtime_o, 64'h1);
    chk("wrap_trint_drop", trint, 1'b0);
    xfer(1'b0, A_MTIME, 64'h0, 8'h00, rd, err, tr_mid);
    chk("mtime_rd_accept_val", rd, 64'h1);

    // Byte-merge
    xfer(1'b1, A_CMP, 64'h1122_3344_5566_7788, 8'h0F, rd, err, tr_mid);
    xfer(1'b0, A_CMP, 64'h0, 8'h00, rd, err, tr_mid);
    chk("merge_cmp_rd", rd, 64'hFFFF_FFFF_5566_7788);

    // Unmapped read with response back-pressure
    bus.req_valid  = 1'b1;
    bus.req_write  = 1'b0;
    bus.req_addr   = BASE + 32'h1000;
    bus.resp_ready = 1'b0;
    @(negedge clk);
    bus.req_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("unmap_hold_valid", bus.resp_valid, 1'b1);
      chk("unmap_hold_err", bus.resp_err, 1'b1);
      chk("unmap_hold_rdata", bus.resp_rdata, 64'h0);
      chk("unmap_hold_ready", bus.req_ready, 1'b0);
      @(negedge clk);
    end
    bus.resp_ready = 1'b1;
    @(negedge clk);
    chk("unmap_release_valid", bus.resp_valid, 1'b0);
    chk("unmap_release_ready", bus.req_ready, 1'b1);
    $display("xfer RD addr=%08h held 3 cycles -> err=1", BASE + 32'h1000);
    xfer(1'b1, BASE + 32'hBFF0, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, rd, err, tr_mid);
    chk("unmap_wr_err", err, 1'b1);
    chk("unmap_wr_rdata", rd, 64'h0);
    xfer(1'b0, A_CMP, 64'h0, 8'h00, rd, err, tr_mid);
    chk("unmap_cmp_intact", rd, 64'hFFFF_FFFF_5566_7788);
    xfer(1'b0, A_MSIP, 64'h0, 8'h00, rd, err, tr_mid);
    chk("unmap_msip_intact", rd, 64'h0);

    // External interrupt pulse, 5 cycles
    ext_irq = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      exp_ex = (k >= LAG) && (k < LAG + 5);
      chk("exint_pulse", exint, exp_ex);
      if (k == 5) ext_irq = 1'b0;
    end
    $display("step ext_irq pulse: lag=%0d", LAG);

    // Reset with a response pending
    xfer(1'b1, A_MSIP, 64'h1, 8'h01, rd, err, tr_mid);
    chk("midrst_swint_set", swint, 1'b1);
    bus.req_valid  = 1'b1;
    bus.req_write  = 1'b1;
    bus.req_addr   = A_CMP;
    bus.req_wdata  = 64'h0;
    bus.req_strb   = 8'hFF;
    bus.resp_ready = 1'b0;
    @(negedge clk);
    bus.req_valid = 1'b0;
    bus.req_strb  = 8'h00;
    chk("midrst_pending", bus.resp_valid, 1'b1);
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_resp_valid", bus.resp_valid, 1'b0);
    chk("midrst_req_ready", bus.req_ready, 1'b1);
    chk("midrst_swint", swint, 1'b0);
    chk("midrst_mtime", mtime_o, 64'h0);
    chk("midrst_trint", trint, 1'b0);
    reset = 1'b0;
    bus.resp_ready = 1'b1;
    xfer(1'b0, A_CMP, 64'h0, 8'h00, rd, err, tr_mid);
    chk("midrst_cmp_reset", rd, 64'hFFFF_FFFF_FFFF_FFFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
